// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Operand widths up to DIV_MAX_W bits go through the common negate helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_MAX_W = 64;

    // Two's-complement negate when neg is set; callers truncate back to their width.
    function automatic logic [DIV_MAX_W-1:0] cond_neg(input logic [DIV_MAX_W-1:0] v,
                                                      input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {r,q} left, trial-subtract d, keep or restore.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // r < d always holds, so the trial fits WIDTH+1 signed bits and its MSB is the sign.
    always_comb begin
        shifted = {r, q[WIDTH-1]};
        trial   = shifted - {1'b0, d};
        q_next  = {q[WIDTH-2:0], ~trial[WIDTH]};
        r_next  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider with start/in_ready request and
// valid/out_ready result handshake.
//
//   state  | meaning
//   IDLE   | in_ready=1, waiting for start
//   DIVIDE | one restoring iteration per cycle, WIDTH cycles
//   FIX    | apply result signs (or divide-by-zero values), load output registers
//   DONE   | valid=1, results held until out_ready
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             in_ready,
    output logic             busy,
    output logic             valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] raw_dvd;
    logic             q_sign;
    logic             r_sign;
    logic             dz_flag;
    logic             ovf_flag;

    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] mag_dvd;
    logic [WIDTH-1:0] mag_dvs;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic             min_by_m1;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (r_next),
        .q_next (q_next)
    );

    // MIN keeps its own bit pattern under negation, which is exactly its unsigned magnitude.
    always_comb begin
        dvd_neg   = is_signed & dividend[WIDTH-1];
        dvs_neg   = is_signed & divisor[WIDTH-1];
        mag_dvd   = WIDTH'(cond_neg(DIV_MAX_W'(dividend), dvd_neg));
        mag_dvs   = WIDTH'(cond_neg(DIV_MAX_W'(divisor), dvs_neg));
        dvs_zero  = (divisor == '0);
        min_by_m1 = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        valid     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                // Divide-by-zero skips the iterations but still passes through FIX,
                // so its result is presented one cycle after acceptance.
                if (start) state_nxt = dvs_zero ? FIX : DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == LAST_STEP) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            raw_dvd     <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            dz_flag     <= 1'b0;
            ovf_flag    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        r_reg       <= '0;
                        q_reg       <= mag_dvd;
                        d_reg       <= mag_dvs;
                        raw_dvd     <= dividend;
                        q_sign      <= dvd_neg ^ dvs_neg;
                        r_sign      <= dvd_neg;
                        dz_flag     <= dvs_zero;
                        ovf_flag    <= min_by_m1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end
                DIVIDE: begin
                    r_reg <= r_next;
                    q_reg <= q_next;
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (dz_flag) begin
                        quotient    <= '1;
                        remainder   <= raw_dvd;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quotient    <= WIDTH'(cond_neg(DIV_MAX_W'(q_reg), q_sign));
                        remainder   <= WIDTH'(cond_neg(DIV_MAX_W'(r_reg), r_sign));
                        div_by_zero <= 1'b0;
                        overflow    <= ovf_flag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and edge-operand checks of seq_divider at WIDTH 8, 16 and 32.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start, is_signed, out_ready, in_ready, busy, valid, div_by_zero, overflow;
    logic [15:0] dividend, divisor, quotient, remainder;

    logic        st8, sg8, or8, ir8, bz8, vl8, dz8, ov8;
    logic [7:0]  dd8, dv8, q8, r8;

    logic        st32, sg32, or32, ir32, bz32, vl32, dz32, ov32;
    logic [31:0] dd32, dv32, q32, r32;

    int n_chk = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .in_ready(in_ready), .busy(busy),
        .valid(valid), .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    seq_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(st8), .is_signed(sg8),
        .dividend(dd8), .divisor(dv8), .in_ready(ir8), .busy(bz8),
        .valid(vl8), .out_ready(or8), .quotient(q8), .remainder(r8),
        .div_by_zero(dz8), .overflow(ov8)
    );

    seq_divider #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(st32), .is_signed(sg32),
        .dividend(dd32), .divisor(dv32), .in_ready(ir32), .busy(bz32),
        .valid(vl32), .out_ready(or32), .quotient(q32), .remainder(r32),
        .div_by_zero(dz32), .overflow(ov32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int w, input logic s, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
        case (w)
            8:       begin st8  = s; sg8  = sgn; dd8  = a[7:0];  dv8  = b[7:0];  end
            16:      begin start = s; is_signed = sgn; dividend = a[15:0]; divisor = b[15:0]; end
            default: begin st32 = s; sg32 = sgn; dd32 = a;       dv32 = b;       end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic v);
        case (w)
            8:       or8 = v;
            16:      out_ready = v;
            default: or32 = v;
        endcase
    endtask

    function automatic logic get_valid(input int w);
        case (w)
            8:       return vl8;
            16:      return valid;
            default: return vl32;
        endcase
    endfunction

    function automatic logic get_irdy(input int w);
        case (w)
            8:       return ir8;
            16:      return in_ready;
            default: return ir32;
        endcase
    endfunction

    // Issue one request (called at a negedge with the DUT idle), wait for valid, accept it.
    task automatic run_div(input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz,
                           output logic ov, output int lat, output logic rdy_seen);
        set_req(w, 1'b1, sgn, a, b);
        @(posedge clk);
        @(negedge clk);
        set_req(w, 1'b0, 1'b0, 32'h0, 32'h0);
        lat      = 0;
        rdy_seen = 1'b0;
        while (!get_valid(w) && lat < 100) begin
            if (get_irdy(w)) rdy_seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        case (w)
            8:       begin q = 32'(q8);       r = 32'(r8);        dz = dz8;         ov = ov8;      end
            16:      begin q = 32'(quotient); r = 32'(remainder); dz = div_by_zero; ov = overflow; end
            default: begin q = q32;           r = r32;            dz = dz32;        ov = ov32;     end
        endcase
        set_ordy(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_ordy(w, 1'b0);
    endtask

    task automatic do_check(input int w, input string tag, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eq, input logic [31:0] er,
                            input logic edz, input logic eov);
        logic [31:0] q, r;
        logic        dz, ov, rdy_seen;
        int          lat;
        run_div(w, sgn, a, b, q, r, dz, ov, lat, rdy_seen);
        check({tag, ".lat"}, 64'(lat), 64'(edz ? 1 : w + 1));
        check({tag, ".quo"}, 64'(q), 64'(eq));
        check({tag, ".rem"}, 64'(r), 64'(er));
        check({tag, ".dz"},  64'(dz), 64'(edz));
        check({tag, ".ovf"}, 64'(ov), 64'(eov));
        check({tag, ".irdy_low"}, 64'(rdy_seen), 64'(0));
    endtask

    function automatic longint sx(input logic [31:0] v, input int w, input logic sgn);
        longint x;
        x = longint'(v) & ((longint'(1) << w) - 1);
        if (sgn && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    // Reference: truncating division on sign/zero-extended 64-bit values.
    task automatic model_check(input int w, input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint as, bs, mask;
        logic [31:0] eq, er;
        logic edz, eov;
        mask = (longint'(1) << w) - 1;
        as   = sx(a, w, sgn);
        bs   = sx(b, w, sgn);
        if (bs == 0) begin
            eq = 32'(mask); er = 32'(longint'(a) & mask); edz = 1'b1; eov = 1'b0;
        end else begin
            eq  = 32'((as / bs) & mask);
            er  = 32'((as % bs) & mask);
            edz = 1'b0;
            eov = sgn && (as == -(longint'(1) << (w - 1))) && (bs == -1);
        end
        do_check(w, $sformatf("w%0d s%0d %0h/%0h", w, sgn, 32'(longint'(a) & mask),
                 32'(longint'(b) & mask)), sgn, a, b, eq, er, edz, eov);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".irdy"}, 64'(in_ready), 64'(1));
        check({tag, ".busy"}, 64'(busy), 64'(0));
        check({tag, ".valid"}, 64'(valid), 64'(0));
        check({tag, ".quo"}, 64'(quotient), 64'(0));
        check({tag, ".rem"}, 64'(remainder), 64'(0));
        check({tag, ".dz"}, 64'(div_by_zero), 64'(0));
        check({tag, ".ovf"}, 64'(overflow), 64'(0));
    endtask

    initial begin
        logic [31:0] edges [5];
        int          lat;

        rst = 1'b1;
        start = 0; is_signed = 0; dividend = 0; divisor = 0; out_ready = 0;
        st8 = 0; sg8 = 0; dd8 = 0; dv8 = 0; or8 = 0;
        st32 = 0; sg32 = 0; dd32 = 0; dv32 = 0; or32 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals("reset");

        do_check(16, "u1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);
        do_check(16, "s-7/2", 1'b1, 32'hFFF9, 32'h0002, 32'hFFFD, 32'hFFFF, 1'b0, 1'b0);
        do_check(16, "u65529/2", 1'b0, 32'hFFF9, 32'h0002, 32'd32764, 32'd1, 1'b0, 1'b0);
        do_check(16, "u5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF, 32'd5, 1'b1, 1'b0);
        do_check(16, "s5/0", 1'b1, 32'd5, 32'd0, 32'hFFFF, 32'd5, 1'b1, 1'b0);
        do_check(16, "sMIN/-1", 1'b1, 32'h8000, 32'hFFFF, 32'h8000, 32'd0, 1'b0, 1'b1);
        do_check(16, "flags_clear", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);

        // Back-pressure with start pulses during DIVIDE and DONE.
        set_req(16, 1'b1, 1'b0, 32'd65535, 32'd255);
        @(posedge clk);
        @(negedge clk);
        set_req(16, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_req(16, 1'b1, 1'b0, 32'd1, 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(16, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        while (!valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("bp.valid_seen", 64'(valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.hold%0d.valid", i), 64'(valid), 64'(1));
            check($sformatf("bp.hold%0d.quo", i), 64'(quotient), 64'(257));
            check($sformatf("bp.hold%0d.rem", i), 64'(remainder), 64'(0));
            set_req(16, i == 2, 1'b0, 32'd1, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        set_req(16, 1'b0, 1'b0, 32'h0, 32'h0);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp.after_hs.valid", 64'(valid), 64'(0));
        check("bp.after_hs.irdy", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        check("bp.no_queue.busy", 64'(busy), 64'(0));
        check("bp.no_queue.irdy", 64'(in_ready), 64'(1));
        do_check(16, "bp.next", 1'b0, 32'd7, 32'd1, 32'd7, 32'd0, 1'b0, 1'b0);

        // Reset during iteration 8.
        set_req(16, 1'b1, 1'b0, 32'd12345, 32'd17);
        @(posedge clk);
        @(negedge clk);
        set_req(16, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("mid.busy", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b0;
        do_check(16, "u12345/17", 1'b0, 32'd12345, 32'd17, 32'd726, 32'd3, 1'b0, 1'b0);

        // Edge operands and random pairs at each width, both modes.
        foreach (edges[k]) edges[k] = 32'h0;
        for (int wi = 0; wi < 3; wi++) begin
            int w;
            w = (wi == 0) ? 8 : (wi == 1) ? 16 : 32;
            edges[0] = 32'd0;
            edges[1] = 32'd1;
            edges[2] = 32'(longint'(1) << (w - 1));
            edges[3] = 32'((longint'(1) << (w - 1)) - 1);
            edges[4] = 32'((longint'(1) << w) - 1);
            for (int sg = 0; sg < 2; sg++) begin
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        model_check(w, sg[0], edges[i], edges[j]);
                for (int n = 0; n < 10; n++)
                    model_check(w, sg[0], $urandom, (n == 3) ? 32'($urandom_range(0, 5)) : $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
